// File: rtl/peripheral_mpram_biu_arb_if.sv
// BIU bundle for the multi-port scratchpad: CORES request ports flattened into packed vectors.
// The slave modport is the RAM side; the master modport is the core/BIU side.
interface peripheral_mpram_biu_arb_if #(
   parameter int XLEN  = 64,
   parameter int PLEN  = 64,
   parameter int CORES = 4
);
   logic [CORES-1:0]      biu_stb_i;
   logic [CORES-1:0]      biu_stb_ack_o;
   logic [CORES-1:0]      biu_d_ack_o;
   logic [CORES*PLEN-1:0] biu_adri_i;
   logic [CORES*PLEN-1:0] biu_adro_o;
   logic [CORES*3-1:0]    biu_size_i;
   logic [CORES*3-1:0]    biu_type_i;
   logic [CORES*3-1:0]    biu_prot_i;
   logic [CORES-1:0]      biu_lock_i;
   logic [CORES-1:0]      biu_we_i;
   logic [CORES*XLEN-1:0] biu_d_i;
   logic [CORES*XLEN-1:0] biu_q_o;
   logic [CORES-1:0]      biu_ack_o;
   logic [CORES-1:0]      biu_err_o;

   modport master (
      output biu_stb_i, biu_adri_i, biu_size_i, biu_type_i, biu_prot_i,
             biu_lock_i, biu_we_i, biu_d_i,
      input  biu_stb_ack_o, biu_d_ack_o, biu_adro_o, biu_q_o, biu_ack_o, biu_err_o
   );

   modport slave (
      input  biu_stb_i, biu_adri_i, biu_size_i, biu_type_i, biu_prot_i,
             biu_lock_i, biu_we_i, biu_d_i,
      output biu_stb_ack_o, biu_d_ack_o, biu_adro_o, biu_q_o, biu_ack_o, biu_err_o
   );
endinterface

// File: rtl/peripheral_mpram_biu_arb.sv
// Shared scratchpad RAM behind CORES BIU ports: round-robin grant with lock, one access per cycle.
// Optional PERIPHERAL_MPRAM_PROT_EN rejects unprivileged accesses below PROT_LIMIT.
//
// state     | meaning
// ST_FREE   | no lock owner, round-robin among all requesters
// ST_LOCKED | owner_q holds the array while its lock input stays high
module peripheral_mpram_biu_arb #(
   parameter int XLEN       = 64,
   parameter int PLEN       = 64,
   parameter int CORES      = 4,
   parameter int DEPTH      = 1024,
   parameter int PROT_LIMIT = 256
) (
   input logic                       clk,
   input logic                       rst,
   peripheral_mpram_biu_arb_if.slave bus
);
   localparam int BYTES = XLEN / 8;
   localparam int LSB_W = $clog2(BYTES);
   localparam int IDX_W = $clog2(DEPTH);
   localparam int PTR_W = (CORES > 1) ? $clog2(CORES) : 1;
   localparam logic [PLEN-1:0] ADR_LIMIT = PLEN'(DEPTH * BYTES);

   typedef enum logic {ST_FREE, ST_LOCKED} lock_state_e;

   lock_state_e           state_q, state_d;
   logic [PTR_W-1:0]      owner_q, owner_d;
   logic [PTR_W-1:0]      ptr_q, ptr_d;
   logic [PTR_W-1:0]      gnt_idx, cand;
   logic                  gnt_vld, lock_hold;
   logic [CORES-1:0]      gnt_oh;

   logic [XLEN-1:0]       mem_q [DEPTH];
   logic [CORES-1:0]      ack_q, err_q;
   logic [CORES*PLEN-1:0] adro_q;
   logic [CORES*XLEN-1:0] q_q;

   int                    gi, off, nbytes;
   logic [PLEN-1:0]       adr;
   logic [2:0]            size, prot;
   logic                  we;
   logic [XLEN-1:0]       wdat;
   logic [IDX_W-1:0]      idx;
   logic [BYTES-1:0]      be;
   logic                  size_err, align_err, range_err, prot_err, acc_err, wr_en;
   logic                  unused_ok;

   // A locked owner that drops its lock releases in that same cycle.
   always_comb begin
      gnt_vld   = 1'b0;
      gnt_idx   = '0;
      cand      = '0;
      lock_hold = (state_q == ST_LOCKED) && bus.biu_lock_i[owner_q];
      if (lock_hold) begin
         gnt_vld = bus.biu_stb_i[owner_q];
         gnt_idx = owner_q;
      end else begin
         for (int i = CORES - 1; i >= 0; i--) begin
            cand = PTR_W'((int'(ptr_q) + i) % CORES);
            if (bus.biu_stb_i[cand]) begin
               gnt_vld = 1'b1;
               gnt_idx = cand;
            end
         end
      end
   end

   always_comb begin
      state_d = state_q;
      owner_d = owner_q;
      ptr_d   = gnt_vld ? PTR_W'((int'(gnt_idx) + 1) % CORES) : ptr_q;
      case (state_q)
         ST_FREE: begin
            if (gnt_vld && bus.biu_lock_i[gnt_idx]) begin
               state_d = ST_LOCKED;
               owner_d = gnt_idx;
            end
         end
         ST_LOCKED: begin
            if (!lock_hold) begin
               if (gnt_vld && bus.biu_lock_i[gnt_idx]) owner_d = gnt_idx;
               else                                    state_d = ST_FREE;
            end
         end
         default: state_d = ST_FREE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= ST_FREE;
         owner_q <= '0;
         ptr_q   <= '0;
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         ptr_q   <= ptr_d;
      end
   end

   always_comb begin
      gi     = int'(gnt_idx);
      adr    = bus.biu_adri_i[gi*PLEN +: PLEN];
      size   = bus.biu_size_i[gi*3 +: 3];
      prot   = bus.biu_prot_i[gi*3 +: 3];
      we     = bus.biu_we_i[gnt_idx];
      wdat   = bus.biu_d_i[gi*XLEN +: XLEN];
      idx    = adr[LSB_W +: IDX_W];
      off    = int'(adr[LSB_W-1:0]);
      nbytes = 1 << size;
      be     = '0;
      for (int b = 0; b < BYTES; b++) begin
         be[b] = (b >= off) && (b < off + nbytes);
      end
      size_err  = size > 3'(LSB_W);
      align_err = (adr[LSB_W-1:0] & LSB_W'(nbytes - 1)) != '0;
      range_err = adr >= ADR_LIMIT;
`ifdef PERIPHERAL_MPRAM_PROT_EN
      prot_err  = !prot[0] && (adr < PLEN'(PROT_LIMIT));
`else
      prot_err  = 1'b0;
`endif
      acc_err   = size_err || align_err || range_err || prot_err;
      wr_en     = gnt_vld && we && !acc_err;
   end

   // Gating with rst drops a write that coincides with reset assertion.
   always_ff @(posedge clk) begin
      if (rst && wr_en) begin
         for (int b = 0; b < BYTES; b++) begin
            if (be[b]) mem_q[idx][b*8 +: 8] <= wdat[b*8 +: 8];
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ack_q  <= '0;
         err_q  <= '0;
         adro_q <= '0;
         q_q    <= '0;
      end else begin
         ack_q <= '0;
         err_q <= '0;
         if (gnt_vld) begin
            adro_q[gi*PLEN +: PLEN] <= adr;
            if (acc_err) begin
               err_q[gnt_idx]          <= 1'b1;
               q_q[gi*XLEN +: XLEN]    <= '0;
            end else begin
               ack_q[gnt_idx] <= 1'b1;
               if (!we) q_q[gi*XLEN +: XLEN] <= mem_q[idx];
            end
         end
      end
   end

   assign gnt_oh            = gnt_vld ? (CORES'(1) << gnt_idx) : '0;
   assign bus.biu_stb_ack_o = gnt_oh;
   assign bus.biu_d_ack_o   = gnt_oh & bus.biu_we_i;
   assign bus.biu_ack_o     = ack_q;
   assign bus.biu_err_o     = err_q;
   assign bus.biu_adro_o    = adro_q;
   assign bus.biu_q_o       = q_q;

   // Burst type is accepted but only single beats exist; upper prot bits carry no meaning here.
   assign unused_ok = ^{bus.biu_type_i, bus.biu_prot_i};
endmodule
